// File: rtl/spi_buffer_arbiter.sv
// Round-robin arbiter that shares one Nbit_MOSI_SPI_Buffer_Combined between two
// packet requesters and chains queued packets back-to-back with no idle gap.
//
// Ports:
//   i_SCK, i_RST               clock (rising edge) and synchronous active-high reset
//   i_REQx/i_DATAx/i_DCx/i_Nx  requester x packet request, bytes, D/C bits, byte count
//   o_GNTx/o_DONEx             one-cycle pulses: packet latched / packet fully shifted
//   o_START/o_DATA/o_DC/o_N_transmit  drive the buffer's inputs
//   i_FINAL_BYTE               buffer's o_MOSI_FINAL_BYTE (rising edge = packet complete)
//   o_BUSY/o_OWNER             a packet is owned / index of its requester
//   o_PKT_COUNT                completed packets, saturating
module spi_buffer_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 8
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic               i_REQ0,
  input  logic [WIDTH*N-1:0] i_DATA0,
  input  logic [N-1:0]       i_DC0,
  input  logic [4:0]         i_N0,
  output logic               o_GNT0,
  output logic               o_DONE0,
  input  logic               i_REQ1,
  input  logic [WIDTH*N-1:0] i_DATA1,
  input  logic [N-1:0]       i_DC1,
  input  logic [4:0]         i_N1,
  output logic               o_GNT1,
  output logic               o_DONE1,
  output logic               o_START,
  output logic [WIDTH*N-1:0] o_DATA,
  output logic [N-1:0]       o_DC,
  output logic [4:0]         o_N_transmit,
  input  logic               i_FINAL_BYTE,
  output logic               o_BUSY,
  output logic               o_OWNER,
  output logic [15:0]        o_PKT_COUNT
);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e             state_q, state_d;
  logic               prio_q, prio_d;    // requester that wins a tie
  logic               final_q;
  logic               owner_q, owner_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic [15:0]        count_q, count_d;
  logic [WIDTH*N-1:0] data_q, data_d;
  logic [N-1:0]       dc_q, dc_d;
  logic [4:0]         n_q, n_d;

  logic       fin_rise;
  logic       decide;
  logic       win;
  logic [1:0] vld;
  logic [1:0] nul;
  logic [4:0] n_eff0, n_eff1;

  always_comb begin
    fin_rise = i_FINAL_BYTE & ~final_q;
    n_eff0   = (i_N0 > 5'(N)) ? 5'(N) : i_N0;
    n_eff1   = (i_N1 > 5'(N)) ? 5'(N) : i_N1;
    vld      = {i_REQ1 & (i_N1 != 5'd0), i_REQ0 & (i_N0 != 5'd0)};
    nul      = {i_REQ1 & (i_N1 == 5'd0), i_REQ0 & (i_N0 == 5'd0)};
    // Decision points: every cycle while idle, or the completion edge of the current packet.
    decide   = (state_q == StIdle) | fin_rise;
    win      = (vld == 2'b11) ? prio_q : vld[1];

    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    count_d = count_q;
    data_d  = data_q;
    dc_d    = dc_q;
    n_d     = n_q;

    if ((state_q == StXfer) && fin_rise) begin
      done_d[owner_q] = 1'b1;
      count_d         = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      state_d         = StIdle;
    end

    if (decide) begin
      // Null packets retire immediately and never touch the pointer or the buffer.
      gnt_d  = gnt_d | nul;
      done_d = done_d | nul;
      if (vld != 2'b00) begin
        gnt_d[win] = 1'b1;
        owner_d    = win;
        prio_d     = ~win;
        state_d    = StXfer;
        if (win) begin
          data_d = i_DATA1;
          dc_d   = i_DC1;
          n_d    = n_eff1;
        end else begin
          data_d = i_DATA0;
          dc_d   = i_DC0;
          n_d    = n_eff0;
        end
      end
    end
  end

  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      final_q <= 1'b0;
      owner_q <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      count_q <= 16'd0;
      data_q  <= '0;
      dc_q    <= '0;
      n_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      final_q <= i_FINAL_BYTE;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      count_q <= count_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      n_q     <= n_d;
    end
  end

  assign o_START      = (state_q == StXfer);
  assign o_BUSY       = (state_q == StXfer);
  assign o_OWNER      = owner_q;
  assign o_GNT0       = gnt_q[0];
  assign o_GNT1       = gnt_q[1];
  assign o_DONE0      = done_q[0];
  assign o_DONE1      = done_q[1];
  assign o_PKT_COUNT  = count_q;
  assign o_DATA       = data_q;
  assign o_DC         = dc_q;
  assign o_N_transmit = n_q;

endmodule
